// File: rtl/sha256_kw_sched_if.sv
// Block-in / round-operand-out bundle for sha256_kw_sched.
// The master drives the block and consumes the beats. The slave is the scheduler.
interface sha256_kw_sched_if #(
    parameter int unsigned LANES = 1
);
    localparam int unsigned LW = LANES * 32;

    logic           blk_valid;
    logic           blk_ready;
    logic [511:0]   blk_data;
    logic           out_valid;
    logic           out_ready;
    logic [5:0]     out_round;
    logic [LW-1:0]  out_w;
    logic [LW-1:0]  out_k;
    logic           out_last;
    logic           busy;

    modport master (
        output blk_valid, blk_data, out_ready,
        input  blk_ready, out_valid, out_round, out_w, out_k, out_last, busy
    );

    modport slave (
        input  blk_valid, blk_data, out_ready,
        output blk_ready, out_valid, out_round, out_w, out_k, out_last, busy
    );
endinterface

// File: rtl/sha256_kw_sched.sv
// SHA-256 round operand generator: streams K[t] and expanded W[t], LANES rounds per beat.
// Optional macro KW_PREADD_EN: out_w carries W+K and out_k is driven to zero.
module sha256_kw_sched #(
    parameter int unsigned LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    sha256_kw_sched_if.slave bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned WIN_N  = 16;
    localparam int unsigned EXT_N  = WIN_N + 4;
    localparam int unsigned LW     = LANES * WORD_W;
    localparam int unsigned ROUNDS = 64;
    localparam logic [5:0]  LAST_T = 6'(ROUNDS - LANES);
    localparam logic [5:0]  STEP   = 6'(LANES);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_lanes_bad
            $error("sha256_kw_sched: LANES must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [31:0] K_TAB [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic {IDLE, RUN} state_e;

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Shift the window by LANES words; later lanes may consume W[j-2] produced by earlier lanes.
    function automatic logic [WIN_N-1:0][WORD_W-1:0] next_window(input logic [WIN_N-1:0][WORD_W-1:0] win);
        logic [EXT_N-1:0][WORD_W-1:0] ext;
        logic [WIN_N-1:0][WORD_W-1:0] nxt;
        ext = '0;
        for (int unsigned i = 0; i < WIN_N; i++) ext[5'(i)] = win[4'(i)];
        for (int unsigned i = 0; i < LANES; i++) begin
            ext[5'(WIN_N + i)] = sig1(ext[5'(WIN_N - 2 + i)]) + ext[5'(WIN_N - 7 + i)]
                               + sig0(ext[5'(WIN_N - 15 + i)]) + ext[5'(i)];
        end
        for (int unsigned i = 0; i < WIN_N; i++) nxt[4'(i)] = ext[5'(i + LANES)];
        return nxt;
    endfunction

    state_e                      state_q, state_d;
    logic [WIN_N-1:0][WORD_W-1:0] win_q, win_d;
    logic [5:0]                  t_q, t_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_last_q, out_last_d;
    logic                        busy_q, busy_d;
    logic                        blk_ready_q, blk_ready_d;
    logic [LW-1:0]               out_w_q, out_w_d;
    logic [LW-1:0]               out_k_q, out_k_d;
    logic                        load_c, clear_c;
    logic [WORD_W-1:0]           w_c, k_c;

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        t_d         = t_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_w_d     = out_w_q;
        out_k_d     = out_k_q;
        load_c      = 1'b0;
        clear_c     = 1'b0;
        w_c         = '0;
        k_c         = '0;

        case (state_q)
            IDLE: begin
                if (bus.blk_valid) begin
                    for (int unsigned i = 0; i < WIN_N; i++)
                        win_d[4'(i)] = bus.blk_data[(WIN_N - 1 - i) * WORD_W +: WORD_W];
                    t_d         = '0;
                    state_d     = RUN;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    load_c      = 1'b1;
                end
            end
            RUN: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        t_d         = '0;
                        clear_c     = 1'b1;
                    end else begin
                        win_d      = next_window(win_q);
                        t_d        = t_q + STEP;
                        out_last_d = (t_d == LAST_T);
                        load_c     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Present the lanes of the window that will be current next cycle.
        if (load_c) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                w_c = win_d[4'(i)];
                k_c = K_TAB[6'(t_d + 6'(i))];
`ifdef KW_PREADD_EN
                out_w_d[i * WORD_W +: WORD_W] = w_c + k_c;
                out_k_d[i * WORD_W +: WORD_W] = '0;
`else
                out_w_d[i * WORD_W +: WORD_W] = w_c;
                out_k_d[i * WORD_W +: WORD_W] = k_c;
`endif
            end
        end else if (clear_c) begin
            out_w_d = '0;
            out_k_d = '0;
        end

        busy_d      = (state_d == RUN);
        blk_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            win_q       <= '0;
            t_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            blk_ready_q <= 1'b1;
            out_w_q     <= '0;
            out_k_q     <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            t_q         <= t_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            blk_ready_q <= blk_ready_d;
            out_w_q     <= out_w_d;
            out_k_q     <= out_k_d;
        end
    end

    assign bus.blk_ready = blk_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_round = t_q;
    assign bus.out_w     = out_w_q;
    assign bus.out_k     = out_k_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
endmodule
